serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b - b_in`, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the combinational ripple adder chain. It trades latency for area in arithmetic datapaths. Operands are captured on a start handshake, and results are held stable until the next operation completes.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; must be at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured when `start` is accepted.
- `b`  in  WIDTH  subtrahend; captured when `start` is accepted.
- `b_in`  in  1  borrow-in; captured when `start` is accepted.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse when results update.
- `diff`  out  WIDTH  registered result; holds the last completed value.
- `b_out`  out  1  registered final borrow; holds the last completed value.
- `overflow`  out  1  registered signed overflow (see Configuration).

## Operation
- States: IDLE, SHIFT.
- IDLE, `start` = 1:
  - load the working shift registers `sa <= a`, `sb <= b`;
  - load `borrow <= b_in`, `cnt <= 0`;
  - go to SHIFT.
- SHIFT, each cycle, using bit 0 of the shift registers:
  - `d = sa[0] ^ sb[0] ^ borrow`;
  - `borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)`;
  - shift `sa` and `sb` right by one;
  - shift `d` into the MSB of the working result register `wr`;
  - increment `cnt`.
- When `cnt == WIDTH-1` in SHIFT:
  - `diff <= {d, wr[WIDTH-1:1]}`;
  - `b_out <= borrow_next`;
  - update `overflow`;
  - `done <= 1`;
  - go to IDLE.
- Output registers `diff`, `b_out` and `overflow` are separate from the working registers. They change only on completion and never show partial results.
- Arithmetic is modulo 2^WIDTH. `b_out` = 1 exactly when `a < b + b_in` (unsigned).
- `start` while `busy` is ignored: no queueing and no effect on the current operation.
- Input operands may change freely after acceptance.

## Timing
- Reset values: state IDLE; `busy`, `done`, `diff`, `b_out`, `overflow`, `cnt`, `borrow` and working registers all 0.
- `start` accepted at edge k:
  - `busy` is high from edge k through edge k+WIDTH;
  - `done`, `diff` and `b_out` update at edge k+WIDTH;
  - latency is WIDTH cycles from acceptance.
- `done` is high for exactly one cycle.
- `start` in the cycle `done` is high is accepted (state is already IDLE). This gives back-to-back throughput of one result per WIDTH cycles.
- `reset` mid-operation:
  - abort at the next edge;
  - all outputs return to 0 and the previous result is lost;
  - no `done` is produced;
  - `start` in the same cycle as `reset` is ignored.

## Configuration
- Macro `SERIAL_SUBTRACTOR_OVERFLOW_EN`.
- Defined: on completion, `overflow <= (a_msb != b_msb) && (diff_msb != a_msb)`, treating operands as two's complement. `a_msb` and `b_msb` are latched at acceptance.
- Undefined: no overflow logic or MSB latches are built. The `overflow` port remains and is tied to 0, so the port list is identical in both builds.

## Structure
- Package `serial_subtractor_pkg`:
  - state typedef `sub_state_t` {IDLE, SHIFT};
  - function returning the counter width, `$clog2(WIDTH)` with a minimum of 1.
- Sub-module `full_subtractor` (inputs `a`, `b`, `bin`; outputs `d`, `bout`): purely combinational. It is instantiated once at the LSB of the shift registers, and all sequencing stays in the top module.

## Test plan
With WIDTH = 4:
- `a=9`, `b=3`, `b_in=0`, start pulse -> after 4 cycles `done` pulses once; `diff=6`, `b_out=0`; `busy` high for exactly 4 cycles.
- `a=3`, `b=9`, `b_in=0` -> `diff=4'hA`, `b_out=1`; `diff` holds its old value (6) throughout the operation.
- `a=0`, `b=0`, `b_in=1` -> `diff=4'hF`, `b_out=1`. Then start again in the `done` cycle with `a=5`, `b=5`, `b_in=0` -> `diff=0`, `b_out=0` exactly 4 cycles later.
- With the macro defined: `a=4'h7`, `b=4'hF` -> `diff=4'h8`, `overflow=1`; then `a=4'h7`, `b=4'h1` -> `diff=6`, `overflow=0`. With the macro undefined: `overflow` stays 0 throughout.
- `start` held high with `a=9`, `b=3` -> after the first `done`, the same inputs are re-accepted immediately; pulsing `start` with `a=1`, `b=1` at cycle 2 instead leaves the result at `diff=6`, unaffected.
- `reset` asserted at cycle 2 of an operation -> next cycle `busy=0`, `diff=0`, `b_out=0`, and no `done` is seen; a new start then completes normally.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and helpers for the bit-serial subtractor
//
// Purpose: FSM state type and counter-width helper used by serial_subtractor.
// Ports: none (package).
// Optional feature macro used elsewhere in this slice: SERIAL_SUBTRACTOR_OVERFLOW_EN.

package serial_subtractor_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sub_state_t;

  // Bit counter width: $clog2(width), never less than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
//
// Purpose: d = a - b - bin for one bit, with borrow out.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, diff = a - b - b_in, LSB first
//
// Purpose: captures operands on start, runs one full-subtractor cell over WIDTH
// cycles, then publishes diff/b_out (and optionally signed overflow) in one step.
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN (signed overflow flag;
// when undefined the overflow port is tied to 0).
// Ports:
//   clk      in  1      clock, rising edge
//   reset    in  1      synchronous active-high reset
//   start    in  1      request, sampled only in IDLE
//   a        in  WIDTH  minuend
//   b        in  WIDTH  subtrahend
//   b_in     in  1      borrow in
//   busy     out 1      high while shifting
//   done     out 1      one-cycle pulse when results update
//   diff     out WIDTH  last completed difference
//   b_out    out 1      last completed borrow out
//   overflow out 1      last completed signed overflow

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             done_q, done_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] wr_next;
  logic             unused_wr_lsb;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic overflow_q, overflow_d;
`endif

  full_subtractor u_fs (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .bin (borrow_q),
    .d   (fs_d),
    .bout(fs_bout)
  );

  // The new bit enters at the MSB; after WIDTH shifts the LSB result has
  // reached bit 0, so the oldest slot of wr_q is never needed.
  assign wr_next       = {fs_d, wr_q[WIDTH-1:1]};
  assign unused_wr_lsb = wr_q[0];

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    overflow_d = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = b_in;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        wr_d     = wr_next;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = wr_next;
          b_out_d = fs_bout;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          // fs_d is the final (sign) bit of the difference.
          overflow_d = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      overflow_q <= overflow_d;
    end
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking scoreboard bench for serial_subtractor

module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
  logic         overflow;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ov;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] held_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .b_out   (b_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: wide subtraction; the sign bit of the W+1-bit result is the borrow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t        e;
    logic [W:0]  full;
    full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    e.diff = full[W-1:0];
    e.bout = full[W];
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    e.ov   = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
`else
    e.ov   = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("b_out", 32'(b_out), 32'(e.bout));
        chk("overflow", 32'(overflow), 32'(e.ov));
        held_diff = e.diff;
      end
    end
  end

  // Launch one operation and follow it to its done sample.
  // keep_start leaves start high afterwards; poke_at injects a start with
  // different operands while busy (must be ignored).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input logic keep_start, input int poke_at);
    sb_q.push_back(model(av, bv, bi));
    a     = av;
    b     = bv;
    b_in  = bi;
    start = 1'b1;
    step();
    start = keep_start;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      chk($sformatf("done_low_c%0d", i), 32'(done), 32'd0);
      chk($sformatf("diff_hold_c%0d", i), 32'(diff), 32'(held_diff));
      if (i == poke_at) begin
        a     = 4'd1;
        b     = 4'd1;
        b_in  = 1'b0;
        start = 1'b1;
      end
      step();
      start = keep_start;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(b_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    step();

    // Basic operations; second one checks diff holds 6 while busy.
    run_op(4'd9, 4'd3, 1'b0, 1'b0, -1);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    run_op(4'd3, 4'd9, 1'b0, 1'b0, -1);
    step();

    // Borrow-in only, then a back-to-back start in the done cycle.
    run_op(4'd0, 4'd0, 1'b1, 1'b0, -1);
    run_op(4'd5, 4'd5, 1'b0, 1'b0, -1);
    step();

    // Signed overflow cases (expected 0 when the feature is not built).
    run_op(4'h7, 4'hF, 1'b0, 1'b0, -1);
    run_op(4'h7, 4'h1, 1'b0, 1'b0, -1);
    step();

    // start held high: re-accepted immediately after done.
    run_op(4'd9, 4'd3, 1'b0, 1'b1, -1);
    run_op(4'd9, 4'd3, 1'b0, 1'b0, -1);
    step();

    // start pulsed mid-operation is ignored.
    run_op(4'd9, 4'd3, 1'b0, 1'b0, 2);
    step();
    chk("no_queued_op_busy", 32'(busy), 32'd0);

    // Reset at cycle 2 of an operation, with start asserted alongside.
    a     = 4'd9;
    b     = 4'd3;
    b_in  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    held_diff = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(b_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      chk($sformatf("abort_no_done_%0d", i), 32'(done), 32'd0);
      step();
    end

    // Normal completion after abort.
    run_op(4'd12, 4'd5, 1'b1, 1'b0, -1);
    run_op(4'd1, 4'd2, 1'b1, 1'b0, -1);
    step();
    chk("final_done_low", 32'(done), 32'd0);
    step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
